// File: rtl/permute_pkg.sv
// permute_pkg: opcodes, format codes and the pipeline stage record
// shared by the quadword shift/rotate/gather/shuffle unit.
package permute_pkg;

    localparam int unsigned QW = 128;
    localparam int unsigned AW = 7;

    localparam logic [10:0] OP_SHLQBI  = 11'b00111011011;
    localparam logic [10:0] OP_SHLQBY  = 11'b00111011111;
    localparam logic [10:0] OP_ROTQBI  = 11'b00111011000;
    localparam logic [10:0] OP_ROTQBY  = 11'b00111011100;
    localparam logic [10:0] OP_SHLQBII = 11'b00111111011;
    localparam logic [10:0] OP_SHLQBYI = 11'b00111111111;
    localparam logic [10:0] OP_ROTQBII = 11'b00111111000;
    localparam logic [10:0] OP_ROTQBYI = 11'b00111111100;
    localparam logic [10:0] OP_GBB     = 11'b00110110010;
    localparam logic [10:0] OP_GBH     = 11'b00110110001;
    localparam logic [10:0] OP_GB      = 11'b00110110000;
    localparam logic [3:0]  OP_SHUFB   = 4'b1011;

    localparam logic [2:0] FMT_RR  = 3'd0;
    localparam logic [2:0] FMT_RRR = 3'd1;
    localparam logic [2:0] FMT_RI7 = 3'd2;

    typedef struct packed {
        logic [QW-1:0] rt;
        logic [AW-1:0] addr;
        logic          we;
    } stage_t;

    // Rotate toward the MSB; n=0 turns the right shift into a full
    // 128-bit shift, which yields zero and leaves x unchanged.
    function automatic logic [QW-1:0] rotl(input logic [QW-1:0] x,
                                           input logic [7:0]    n);
        return (x << n) | (x >> (8'd128 - n));
    endfunction

endpackage

// File: rtl/permute_core.sv
// permute_core: combinational quadword permute datapath.
// Ports: op/format/ra/rb/rc/imm_lo in, result_o + valid_o (supported op).
module permute_core
    import permute_pkg::*;
(
    input  logic [10:0]   op_i,
    input  logic [2:0]    format_i,
    input  logic [QW-1:0] ra_i,
    input  logic [QW-1:0] rb_i,
    input  logic [QW-1:0] rc_i,
    input  logic [4:0]    imm_lo_i,
    output logic [QW-1:0] result_o,
    output logic          valid_o
);

    // Operands are big-endian: architectural bit 0 is vector bit 127,
    // so the preferred-slot count field rb[27:31] sits at [100:96].
    logic          rr;
    logic          ri7;
    logic          rrr;
    logic [2:0]    bit_n;
    logic [4:0]    byte_n;
    logic [QW-1:0] shl_bit;
    logic [QW-1:0] shl_byte;
    logic [QW-1:0] rot_bit;
    logic [QW-1:0] rot_byte;
    logic [QW-1:0] gbb_r;
    logic [QW-1:0] gbh_r;
    logic [QW-1:0] gb_r;
    logic [QW-1:0] shuf_r;
    logic [255:0]  cat;
    logic [7:0]    sel;

    assign rr  = (format_i == FMT_RR);
    assign ri7 = (format_i == FMT_RI7);
    assign rrr = (format_i == FMT_RRR);

    assign bit_n  = ri7 ? imm_lo_i[2:0] : rb_i[98:96];
    assign byte_n = ri7 ? imm_lo_i : rb_i[100:96];

    assign shl_bit  = ra_i << bit_n;
    assign shl_byte = byte_n[4] ? '0 : (ra_i << {byte_n[3:0], 3'b000});
    assign rot_bit  = rotl(ra_i, {5'd0, bit_n});
    assign rot_byte = rotl(ra_i, {1'b0, byte_n[3:0], 3'b000});

    assign cat = {ra_i, rb_i};

    always_comb begin
        gbb_r  = '0;
        gbh_r  = '0;
        gb_r   = '0;
        shuf_r = '0;
        sel    = '0;
        for (int i = 0; i < 16; i++) gbb_r[111-i] = ra_i[120-8*i];
        for (int i = 0; i < 8; i++)  gbh_r[103-i] = ra_i[112-16*i];
        for (int i = 0; i < 4; i++)  gb_r[99-i]   = ra_i[96-32*i];
        for (int j = 0; j < 16; j++) begin
            sel = rc_i[127-8*j -: 8];
            if (sel[7:6] == 2'b10)
                shuf_r[127-8*j -: 8] = 8'h00;
            else if (sel[7:5] == 3'b110)
                shuf_r[127-8*j -: 8] = 8'hFF;
            else if (sel[7:5] == 3'b111)
                shuf_r[127-8*j -: 8] = 8'h80;
            else
                shuf_r[127-8*j -: 8] = cat[255-8*int'(sel[4:0]) -: 8];
        end
    end

    always_comb begin
        result_o = '0;
        valid_o  = 1'b0;
        unique case (1'b1)
            rr && op_i == OP_SHLQBI:   begin result_o = shl_bit;  valid_o = 1'b1; end
            rr && op_i == OP_SHLQBY:   begin result_o = shl_byte; valid_o = 1'b1; end
            rr && op_i == OP_ROTQBI:   begin result_o = rot_bit;  valid_o = 1'b1; end
            rr && op_i == OP_ROTQBY:   begin result_o = rot_byte; valid_o = 1'b1; end
            rr && op_i == OP_GBB:      begin result_o = gbb_r;    valid_o = 1'b1; end
            rr && op_i == OP_GBH:      begin result_o = gbh_r;    valid_o = 1'b1; end
            rr && op_i == OP_GB:       begin result_o = gb_r;     valid_o = 1'b1; end
            ri7 && op_i == OP_SHLQBII: begin result_o = shl_bit;  valid_o = 1'b1; end
            ri7 && op_i == OP_SHLQBYI: begin result_o = shl_byte; valid_o = 1'b1; end
            ri7 && op_i == OP_ROTQBII: begin result_o = rot_bit;  valid_o = 1'b1; end
            ri7 && op_i == OP_ROTQBYI: begin result_o = rot_byte; valid_o = 1'b1; end
            rrr && op_i[10:7] == OP_SHUFB: begin result_o = shuf_r; valid_o = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/permute_unit_p.sv
// permute_unit_p: DEPTH-stage pipelined permute unit with flush,
// writeback port (rt_wb/rt_addr_wb/reg_write_wb) and per-stage forwarding.
module permute_unit_p
    import permute_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter bit FWD_EN = 1'b1
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           op,
    input  logic [2:0]            format,
    input  logic [AW-1:0]         rt_addr,
    input  logic [QW-1:0]         ra,
    input  logic [QW-1:0]         rb,
    input  logic [QW-1:0]         rc,
    input  logic [17:0]           imm,
    input  logic                  reg_write,
    input  logic                  flush,
    output logic [QW-1:0]         rt_wb,
    output logic [AW-1:0]         rt_addr_wb,
    output logic                  reg_write_wb,
    output logic [DEPTH*QW-1:0]   fwd_rt,
    output logic [DEPTH*AW-1:0]   fwd_addr,
    output logic [DEPTH-1:0]      fwd_we
);

    logic [QW-1:0] core_res;
    logic          core_ok;
    logic          unused_imm;
    stage_t        stg_d;
    stage_t        stg_q [DEPTH];

    // Only imm7's low five bits ever act as a count.
    assign unused_imm = ^imm[17:5];

    permute_core u_core (
        .op_i     (op),
        .format_i (format),
        .ra_i     (ra),
        .rb_i     (rb),
        .rc_i     (rc),
        .imm_lo_i (imm[4:0]),
        .result_o (core_res),
        .valid_o  (core_ok)
    );

    // Flush also kills the instruction being captured this edge.
    assign stg_d = '{rt: core_res, addr: rt_addr,
                     we: core_ok & reg_write & ~flush};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) stg_q[k] <= '0;
        end else begin
            stg_q[0] <= stg_d;
            for (int k = 1; k < DEPTH; k++) begin
                stg_q[k] <= '{rt: stg_q[k-1].rt, addr: stg_q[k-1].addr,
                              we: stg_q[k-1].we & ~flush};
            end
        end
    end

    assign rt_wb        = stg_q[DEPTH-1].rt;
    assign rt_addr_wb   = stg_q[DEPTH-1].addr;
    assign reg_write_wb = stg_q[DEPTH-1].we;

    for (genvar k = 0; k < DEPTH; k++) begin : g_fwd
        if (FWD_EN) begin : g_on
            assign fwd_rt[k*QW +: QW]   = stg_q[k].rt;
            assign fwd_addr[k*AW +: AW] = stg_q[k].addr;
            assign fwd_we[k]            = stg_q[k].we;
        end else begin : g_off
            assign fwd_rt[k*QW +: QW]   = '0;
            assign fwd_addr[k*AW +: AW] = '0;
            assign fwd_we[k]            = 1'b0;
        end
    end

endmodule
